muldiv_sequencer: RTL and testbench

Multi-cycle controller for the RV32M multiply/divide operations that sit beside the single-cycle ALU in the execute stage. It captures forwarded operands when the execute stage issues an M-extension op and runs an iterative shift-add multiplier or restoring divider. While the result is pending it stalls the pipeline, then presents the registered result for one cycle. It also handles the RISC-V divide-by-zero and signed-overflow corner cases without iterating.

---
 rtl/muldiv_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide controller for the execute stage.
// Shift-add multiplier and restoring divider share one 64-bit accumulator.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   m_q;
  logic [2*XLEN-1:0] acc;

  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              is_div;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;

  assign a_signed = (op == OP_MULH) | (op == OP_MULHSU)
                  | (op == OP_DIV) | (op == OP_REM);
  assign b_signed = (op == OP_MULH) | (op == OP_DIV)
                  | (op == OP_REM);
  assign a_neg    = a_signed & operand_a[XLEN-1];
  assign b_neg    = b_signed & operand_b[XLEN-1];
  assign a_mag    = a_neg ? -operand_a : operand_a;
  assign b_mag    = b_neg ? -operand_b : operand_b;
  assign is_div   = op[2];
  assign div_zero = is_div & (operand_b == '0);
  assign div_ovf  = ((op == OP_DIV) | (op == OP_REM))
                  & (operand_a == SMIN)
                  & (operand_b == '1);

  always_comb begin
    special_res = '0;
    unique case (1'b1)
      div_zero: special_res = op[1] ? operand_a : '1;
      div_ovf:  special_res = op[1] ? '0 : SMIN;
      default:  special_res = '0;
    endcase
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                  + (acc[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // acc holds {partial remainder, dividend shifting into quotient}
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_next  = {div_ge ? div_diff[XLEN-1:0]
                             : div_shift[XLEN-1:0],
                      acc[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  assign prod = neg_q ? -acc : acc;
  assign quot = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    unique case (op_q)
      OP_MUL:
        fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:
        fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        fix_res = neg_q ? -quot : quot;
      OP_REM, OP_REMU:
        fix_res = neg_q ? -rem : rem;
      default:
        fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      m_q    <= '0;
      acc    <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            cnt   <= '0;
            // remainder follows the dividend; all else the sign product
            neg_q <= (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
            m_q   <= is_div ? b_mag : a_mag;
            acc   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            if (div_zero || div_ovf) begin
              result <= special_res;
              valid  <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fix_res;
            valid  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = state != IDLE;
  assign stall = reset_n
               & (((state == IDLE) & start & ~flush)
                 | (state == CALC)
                 | (state == FIX));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus
// flush, reset and back-to-back sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .valid     (valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int got;
    int nstall;
    logic [31:0] res;
    @(negedge clk);
    op = v.op;
    operand_a = v.a;
    operand_b = v.b;
    start = 1'b1;
    #1;
    chk($sformatf("vec%0d stall_c0", idx), 32'(stall), 32'd1);
    got = -1;
    nstall = 1;
    res = '0;
    for (int c = 1; c <= 40 && got < 0; c++) begin
      @(negedge clk);
      if (stall) nstall++;
      if (valid) begin
        got = c;
        res = result;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk($sformatf("vec%0d valid_cycle", idx), 32'(got), 32'(v.lat));
    chk($sformatf("vec%0d result", idx), res, v.exp);
    chk($sformatf("vec%0d stall_cycles", idx),
        32'(nstall), 32'(v.lat));
    @(negedge clk);
    chk($sformatf("vec%0d idle_after", idx),
        {30'd0, valid, busy}, 32'd0);
  endtask

  initial begin
    int got;
    int nvalid;
    int p1;
    int p2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] prior;

    vecs[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34};
    vecs[2]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[3]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[4]  = '{MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
    vecs[5]  = '{DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1};
    vecs[6]  = '{REM,    32'd100,      32'd0,        32'd100,      1};
    vecs[7]  = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[8]  = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[9]  = '{DIVU,   32'd100,      32'd7,        32'd14,       34};
    vecs[10] = '{REMU,   32'd100,      32'd7,        32'd2,        34};
    vecs[11] = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[12] = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[13] = '{DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34};
    vecs[14] = '{REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 34};
    vecs[15] = '{DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34};
    vecs[16] = '{DIV,    32'h80000000, 32'd2,        32'hC0000000, 34};

    #2;
    chk("reset_outputs", {29'd0, valid, busy, stall}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op(i, vecs[i]);

    // flush mid-divide, then a fresh multiply in the following cycle
    @(negedge clk);
    prior = result;
    op = DIV;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start = 1'b1;
    nvalid = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {29'd0, valid, busy, stall}, 32'd0);
    chk("flush_no_valid", 32'(nvalid), 32'd0);
    chk("flush_result_kept", result, prior);
    op = MUL;
    operand_a = 32'd3;
    operand_b = 32'd5;
    start = 1'b1;
    got = -1;
    r1 = '0;
    for (int c = 12; c <= 50 && got < 0; c++) begin
      @(negedge clk);
      if (valid) begin
        got = c;
        r1 = result;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("restart_cycle", 32'(got), 32'd45);
    chk("restart_result", r1, 32'd15);

    // asynchronous reset mid-multiply
    @(negedge clk);
    @(negedge clk);
    op = MUL;
    operand_a = 32'h1234;
    operand_b = 32'h5678;
    start = 1'b1;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {29'd0, valid, busy, stall}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid || busy) nvalid++;
    end
    chk("rst_no_valid", 32'(nvalid), 32'd0);

    // back-to-back multiplies with start held across DONE
    @(negedge clk);
    op = MUL;
    operand_a = 32'd3;
    operand_b = 32'd5;
    start = 1'b1;
    nvalid = 0;
    p1 = -1;
    p2 = -1;
    r1 = '0;
    r2 = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (valid) begin
        nvalid++;
        if (nvalid == 1) begin
          p1 = c;
          r1 = result;
          operand_a = 32'd6;
          operand_b = 32'd7;
        end else begin
          p2 = c;
          r2 = result;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 32'(nvalid), 32'd2);
    chk("b2b_first_cycle", 32'(p1), 32'd34);
    chk("b2b_first_result", r1, 32'd15);
    chk("b2b_second_cycle", 32'(p2), 32'd69);
    chk("b2b_second_result", r2, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
